// File: rtl/bsg_chip_pkg.sv
// Shared types and codes for the gateway loopback test controller.
// BSG_SAFE_CLOG2 is defined here when the surrounding codebase has not already defined it.
`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) <= 1) ? 1 : $clog2(x))
`endif

package bsg_chip_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RESET = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    CHECK = 3'd4,
    DONE  = 3'd5
  } gw_lb_state_e;

  localparam logic [1:0] gw_lb_fail_none_gp = 2'b00;
  localparam logic [1:0] gw_lb_fail_err_gp  = 2'b01;
  localparam logic [1:0] gw_lb_fail_cnt_gp  = 2'b10;

endpackage

// File: rtl/bsg_gateway_loopback_node_check.sv
// Selects one test node by index and classifies it: error flag first, then sent/received equality.
module bsg_gateway_loopback_node_check
  import bsg_chip_pkg::*;
#(
  parameter int num_nodes_p   = 20,
  parameter int count_width_p = 32,
  parameter int idx_width_p   = 5
) (
  input  logic [idx_width_p-1:0]               idx_i,
  input  logic [num_nodes_p-1:0]               node_error_i,
  input  logic [num_nodes_p*count_width_p-1:0] node_sent_i,
  input  logic [num_nodes_p*count_width_p-1:0] node_received_i,
  output logic [1:0]                           fail_code_o
);

  logic [count_width_p-1:0] sent_sel;
  logic [count_width_p-1:0] recv_sel;
  logic                     err_sel;

  always_comb begin
    sent_sel    = node_sent_i[count_width_p*int'(idx_i) +: count_width_p];
    recv_sel    = node_received_i[count_width_p*int'(idx_i) +: count_width_p];
    err_sel     = node_error_i[idx_i];
    fail_code_o = gw_lb_fail_none_gp;
    if (err_sel)
      fail_code_o = gw_lb_fail_err_gp;
    else if (sent_sel != recv_sel)
      fail_code_o = gw_lb_fail_cnt_gp;
  end

endmodule

// File: rtl/bsg_gateway_loopback_test_ctrl.sv
// Loopback test pass sequencer: reset nodes, run traffic, drain, scan per-node results.
// Optional BSG_GATEWAY_LOOPBACK_STATS_EN adds a saturating total_sent_o accumulator.
//
//  state | meaning
//  IDLE  | waiting for start with init done; nodes held in reset
//  RESET | nodes in reset for reset_cycles_p cycles
//  RUN   | traffic enabled for run_cycles_p cycles
//  DRAIN | traffic disabled, in-flight packets settle for drain_cycles_p cycles
//  CHECK | scan one node per cycle, stop at first failure
//  DONE  | result valid and held until next accepted start
module bsg_gateway_loopback_test_ctrl
  import bsg_chip_pkg::*;
#(
  parameter int num_nodes_p    = 20,
  parameter int count_width_p  = 32,
  parameter int reset_cycles_p = 16,
  parameter int run_cycles_p   = 5000,
  parameter int drain_cycles_p = 500
) (
  input  logic                                     clk_i,
  input  logic                                     reset_n_i,
  input  logic                                     init_done_i,
  input  logic                                     start_i,
  input  logic [num_nodes_p-1:0]                   node_error_i,
  input  logic [num_nodes_p*count_width_p-1:0]     node_sent_i,
  input  logic [num_nodes_p*count_width_p-1:0]     node_received_i,
  output logic                                     node_reset_o,
  output logic                                     node_en_o,
  output logic                                     busy_o,
  output logic                                     done_o,
  output logic                                     pass_o,
  output logic [`BSG_SAFE_CLOG2(num_nodes_p)-1:0]  fail_idx_o,
`ifdef BSG_GATEWAY_LOOPBACK_STATS_EN
  output logic [1:0]                               fail_code_o,
  output logic [count_width_p+8-1:0]               total_sent_o
`else
  output logic [1:0]                               fail_code_o
`endif
);

  localparam int max_rr_lp     = (reset_cycles_p > run_cycles_p) ? reset_cycles_p : run_cycles_p;
  localparam int max_cycles_lp = (max_rr_lp > drain_cycles_p) ? max_rr_lp : drain_cycles_p;
  localparam int cnt_width_lp  = $clog2(max_cycles_lp + 1);
  localparam int idx_width_lp  = `BSG_SAFE_CLOG2(num_nodes_p);

  localparam logic [cnt_width_lp-1:0] reset_load_lp = cnt_width_lp'(reset_cycles_p - 1);
  localparam logic [cnt_width_lp-1:0] run_load_lp   = cnt_width_lp'(run_cycles_p - 1);
  localparam logic [cnt_width_lp-1:0] drain_load_lp = cnt_width_lp'(drain_cycles_p - 1);
  localparam logic [idx_width_lp-1:0] last_idx_lp   = idx_width_lp'(num_nodes_p - 1);

  gw_lb_state_e              state_r, state_n;
  logic [cnt_width_lp-1:0]   cnt_r, cnt_n;
  logic [idx_width_lp-1:0]   idx_r, idx_n;
  logic                      pass_n;
  logic [idx_width_lp-1:0]   fail_idx_n;
  logic [1:0]                fail_code_n;
  logic [1:0]                chk_code;
  logic                      start_ok;
  logic                      clear_res;
  logic                      accum_en;

  bsg_gateway_loopback_node_check #(
    .num_nodes_p   (num_nodes_p),
    .count_width_p (count_width_p),
    .idx_width_p   (idx_width_lp)
  ) node_check (
    .idx_i           (idx_r),
    .node_error_i    (node_error_i),
    .node_sent_i     (node_sent_i),
    .node_received_i (node_received_i),
    .fail_code_o     (chk_code)
  );

  assign start_ok = start_i & init_done_i;

  always_comb begin
    state_n     = state_r;
    cnt_n       = cnt_r;
    idx_n       = idx_r;
    pass_n      = pass_o;
    fail_idx_n  = fail_idx_o;
    fail_code_n = fail_code_o;
    clear_res   = 1'b0;
    accum_en    = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (start_ok) begin
          state_n   = RESET;
          cnt_n     = reset_load_lp;
          clear_res = 1'b1;
        end
      end
      RESET: begin
        if (!init_done_i) state_n = IDLE;
        else if (cnt_r == '0) begin
          state_n = RUN;
          cnt_n   = run_load_lp;
        end else cnt_n = cnt_r - cnt_width_lp'(1);
      end
      RUN: begin
        if (!init_done_i) state_n = IDLE;
        else if (cnt_r == '0) begin
          state_n = DRAIN;
          cnt_n   = drain_load_lp;
        end else cnt_n = cnt_r - cnt_width_lp'(1);
      end
      DRAIN: begin
        if (!init_done_i) state_n = IDLE;
        else if (cnt_r == '0) begin
          state_n = CHECK;
          idx_n   = '0;
        end else cnt_n = cnt_r - cnt_width_lp'(1);
      end
      CHECK: begin
        if (!init_done_i) state_n = IDLE;
        else begin
          accum_en = 1'b1;
          if (chk_code != gw_lb_fail_none_gp) begin
            state_n     = DONE;
            pass_n      = 1'b0;
            fail_idx_n  = idx_r;
            fail_code_n = chk_code;
          end else if (idx_r == last_idx_lp) begin
            state_n = DONE;
            pass_n  = 1'b1;
          end else idx_n = idx_r + idx_width_lp'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    if (clear_res) begin
      pass_n      = 1'b0;
      fail_idx_n  = '0;
      fail_code_n = gw_lb_fail_none_gp;
    end
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r      <= IDLE;
      cnt_r        <= '0;
      idx_r        <= '0;
      node_reset_o <= 1'b1;
      node_en_o    <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      pass_o       <= 1'b0;
      fail_idx_o   <= '0;
      fail_code_o  <= gw_lb_fail_none_gp;
    end else begin
      state_r      <= state_n;
      cnt_r        <= cnt_n;
      idx_r        <= idx_n;
      node_reset_o <= (state_n == IDLE) || (state_n == RESET);
      node_en_o    <= (state_n == RUN);
      busy_o       <= (state_n == RESET) || (state_n == RUN) ||
                      (state_n == DRAIN) || (state_n == CHECK);
      done_o       <= (state_n == DONE);
      pass_o       <= pass_n;
      fail_idx_o   <= fail_idx_n;
      fail_code_o  <= fail_code_n;
    end
  end

`ifdef BSG_GATEWAY_LOOPBACK_STATS_EN
  localparam int tot_width_lp = count_width_p + 8;

  logic [count_width_p-1:0] stat_sent;
  logic [tot_width_lp:0]    stat_sum;
  logic [tot_width_lp-1:0]  total_n;

  always_comb begin
    stat_sent = node_sent_i[count_width_p*int'(idx_r) +: count_width_p];
    stat_sum  = {1'b0, total_sent_o} + {9'b0, stat_sent};
    total_n   = total_sent_o;
    if (clear_res) total_n = '0;
    else if (accum_en) total_n = stat_sum[tot_width_lp] ? '1 : stat_sum[tot_width_lp-1:0];
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) total_sent_o <= '0;
    else            total_sent_o <= total_n;
  end
`else
  logic unused_accum;
  assign unused_accum = accum_en;
`endif

endmodule

// File: tb/tb_bsg_gateway_loopback_test_ctrl.sv
// Directed bench for bsg_gateway_loopback_test_ctrl (reset 4, run 100, drain 20, 20 nodes).
module tb_bsg_gateway_loopback_test_ctrl;

  localparam int nodes_lp = 20;
  localparam int cw_lp    = 32;
  localparam int clean_cycles_lp = 4 + 100 + 20 + 20;

  logic                      clk_i = 1'b0;
  logic                      reset_n_i;
  logic                      init_done_i;
  logic                      start_i;
  logic [nodes_lp-1:0]       node_error_i;
  logic [nodes_lp*cw_lp-1:0] node_sent_i;
  logic [nodes_lp*cw_lp-1:0] node_received_i;
  logic                      node_reset_o;
  logic                      node_en_o;
  logic                      busy_o;
  logic                      done_o;
  logic                      pass_o;
  logic [4:0]                fail_idx_o;
  logic [1:0]                fail_code_o;
`ifdef BSG_GATEWAY_LOOPBACK_STATS_EN
  logic [cw_lp+8-1:0]        total_sent_o;
`endif

  int checks = 0;
  int errors = 0;
  int cyc;
  int en_cnt;

  always #5 clk_i = ~clk_i;

  bsg_gateway_loopback_test_ctrl #(
    .num_nodes_p(nodes_lp), .count_width_p(cw_lp),
    .reset_cycles_p(4), .run_cycles_p(100), .drain_cycles_p(20)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .init_done_i(init_done_i), .start_i(start_i),
    .node_error_i(node_error_i), .node_sent_i(node_sent_i), .node_received_i(node_received_i),
    .node_reset_o(node_reset_o), .node_en_o(node_en_o), .busy_o(busy_o), .done_o(done_o),
    .pass_o(pass_o), .fail_idx_o(fail_idx_o),
`ifdef BSG_GATEWAY_LOOPBACK_STATS_EN
    .fail_code_o(fail_code_o), .total_sent_o(total_sent_o)
`else
    .fail_code_o(fail_code_o)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_all(input logic [31:0] val);
    node_error_i = '0;
    for (int n = 0; n < nodes_lp; n++) begin
      node_sent_i[n*cw_lp +: cw_lp]     = val;
      node_received_i[n*cw_lp +: cw_lp] = val;
    end
  endtask

  task automatic start_pass();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_done(output int c, output int e);
    c = 0;
    e = 0;
    while (!done_o && c < 1000) begin
      if (node_en_o) e++;
      tick();
      c++;
    end
  endtask

  initial begin
    reset_n_i   = 1'b0;
    init_done_i = 1'b0;
    start_i     = 1'b0;
    set_all(32'd37);
    repeat (3) tick();
    chk("rst_node_reset", node_reset_o, 1);
    chk("rst_node_en", node_en_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_pass", pass_o, 0);
    chk("rst_fail_idx", fail_idx_o, 0);
    chk("rst_fail_code", fail_code_o, 0);
    reset_n_i = 1'b1;
    tick();

    // 1: clean pass
    init_done_i = 1'b1;
    start_pass();
    chk("t1_busy_after_start", busy_o, 1);
    chk("t1_node_reset_in_reset", node_reset_o, 1);
    wait_done(cyc, en_cnt);
    chk("t1_done_latency", cyc, clean_cycles_lp);
    chk("t1_en_cycles", en_cnt, 100);
    chk("t1_pass", pass_o, 1);
    chk("t1_fail_code", fail_code_o, 0);
    chk("t1_fail_idx", fail_idx_o, 0);
    chk("t1_busy_done", busy_o, 0);
    chk("t1_node_reset_done", node_reset_o, 0);
    tick();
    chk("t1_done_held", done_o, 1);

    // 2: node 7 count mismatch; restart from DONE clears results
    node_received_i[7*cw_lp +: cw_lp] = 32'd36;
    start_pass();
    chk("t2_done_cleared", done_o, 0);
    chk("t2_pass_cleared", pass_o, 0);
    wait_done(cyc, en_cnt);
    chk("t2_latency", cyc, 124 + 8);
    chk("t2_pass", pass_o, 0);
    chk("t2_fail_idx", fail_idx_o, 7);
    chk("t2_fail_code", fail_code_o, 2);

    // 3: lowest index wins, error beats mismatch
    set_all(32'd37);
    node_error_i[3] = 1'b1;
    node_received_i[3*cw_lp +: cw_lp] = 32'd36;
    node_received_i[1*cw_lp +: cw_lp] = 32'd36;
    start_pass();
    chk("t3_fail_code_cleared", fail_code_o, 0);
    chk("t3_fail_idx_cleared", fail_idx_o, 0);
    wait_done(cyc, en_cnt);
    chk("t3a_latency", cyc, 124 + 2);
    chk("t3a_fail_idx", fail_idx_o, 1);
    chk("t3a_fail_code", fail_code_o, 2);
    node_received_i[1*cw_lp +: cw_lp] = 32'd37;
    start_pass();
    wait_done(cyc, en_cnt);
    chk("t3b_latency", cyc, 124 + 4);
    chk("t3b_fail_idx", fail_idx_o, 3);
    chk("t3b_fail_code", fail_code_o, 1);

    // 4: abort mid-RUN, then start without init is ignored
    set_all(32'd37);
    start_pass();
    repeat (10) tick();
    chk("t4_in_run", node_en_o, 1);
    init_done_i = 1'b0;
    tick();
    chk("t4_abort_en", node_en_o, 0);
    chk("t4_abort_node_reset", node_reset_o, 1);
    chk("t4_abort_done", done_o, 0);
    chk("t4_abort_busy", busy_o, 0);
    start_i = 1'b1;
    repeat (3) tick();
    start_i = 1'b0;
    chk("t4_no_init_busy", busy_o, 0);
    chk("t4_no_init_node_reset", node_reset_o, 1);
    init_done_i = 1'b1;
    tick();
    chk("t4_stays_idle", busy_o, 0);

    // 5: start during RUN ignored, then async reset mid-DRAIN
    start_pass();
    repeat (10) tick();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    wait_done(cyc, en_cnt);
    chk("t5_run_start_ignored", cyc + 11, clean_cycles_lp);
    chk("t5_pass", pass_o, 1);
    start_pass();
    repeat (110) tick();
    chk("t5_in_drain_en", node_en_o, 0);
    chk("t5_in_drain_busy", busy_o, 1);
    #2;
    reset_n_i = 1'b0;
    #1;
    chk("t5_async_node_reset", node_reset_o, 1);
    chk("t5_async_busy", busy_o, 0);
    chk("t5_async_en", node_en_o, 0);
    chk("t5_async_done", done_o, 0);
    chk("t5_async_pass", pass_o, 0);
    #1;
    reset_n_i = 1'b1;
    tick();
    chk("t5_idle_after_reset", busy_o, 0);

`ifdef BSG_GATEWAY_LOOPBACK_STATS_EN
    // 6: accumulated sent count
    set_all(32'd1000);
    start_pass();
    chk("t6_total_cleared", total_sent_o, 0);
    wait_done(cyc, en_cnt);
    chk("t6_total_sent", total_sent_o, 20000);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
